// File: rtl/mem_access_unit.sv
// Memory access unit for the MEM pipeline stage.
// Fronts a single-port 2^AW x 32 data RAM. A 32-bit store completes in one
// cycle, while a 32-bit load and a 64-bit store each take two cycles. Two-cycle
// accesses raise Mem_stall in their first cycle so that upstream holds its inputs.
module mem_access_unit #(
  parameter int AW = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemWrite64,
  input  logic [31:0] Adrs_MEM,
  input  logic [31:0] Rt_data_MEM,
  input  logic [63:0] Rt_data64_MEM,
  output logic [31:0] Read_data_MEM,
  output logic        Mem_stall,
  output logic        Mem_done
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR64_HI = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0] ram [0:DEPTH-1];

  // Word indices: the low word of a 64-bit store uses idx. The high word uses
  // idx+1, which wraps at the top of the RAM through natural AW-bit overflow.
  logic [AW-1:0] idx;
  logic [AW-1:0] hi_idx;
  assign idx    = Adrs_MEM[AW+1:2];
  assign hi_idx = idx + AW'(1);

  // Byte-offset and out-of-range address bits do not select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Adrs_MEM[31:AW+2], Adrs_MEM[1:0]};

  // Request decode in priority order. A lower-priority request that arrives
  // together with a higher-priority one is dropped.
  logic req_wr64;
  logic req_wr;
  logic req_rd;
  assign req_wr64 = MemWrite64;
  assign req_wr   = MemWrite & ~MemWrite64;
  assign req_rd   = MemRead & ~MemWrite & ~MemWrite64;

  // The single RAM port is shared. Each cycle performs at most one read or one write.
  logic          ram_we;
  logic          rd_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;

  // Decode the port operation, the next state and the handshake outputs from state and requests.
  always_comb begin
    // NOTE: every signal gets a default before the case. Without it, a path
    // that does not assign a signal would infer a latch.
    ram_we     = 1'b0;
    rd_en      = 1'b0;
    ram_addr   = idx;
    ram_wdata  = Rt_data_MEM;
    next_state = state;
    Mem_stall  = 1'b0;
    Mem_done   = 1'b0;

    if (!Reset) begin
      unique case (state)
        IDLE: begin
          if (req_wr64) begin
            ram_we     = 1'b1;
            ram_wdata  = Rt_data64_MEM[31:0];
            Mem_stall  = 1'b1;
            next_state = WR64_HI;
          end else if (req_wr) begin
            ram_we     = 1'b1;
            Mem_done   = 1'b1;
          end else if (req_rd) begin
            rd_en      = 1'b1;
            Mem_stall  = 1'b1;
            next_state = RD_WAIT;
          end
        end

        // Load data was captured at the previous edge and is now valid.
        RD_WAIT: begin
          Mem_done   = 1'b1;
          next_state = IDLE;
        end

        // Upstream is still holding the address and data, so the high word is taken from them.
        WR64_HI: begin
          ram_we     = 1'b1;
          ram_addr   = hi_idx;
          ram_wdata  = Rt_data64_MEM[63:32];
          Mem_done   = 1'b1;
          next_state = IDLE;
        end

        default: next_state = IDLE;
      endcase
    end
  end

  // State register and load data register. Reset returns to IDLE and clears the load data.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge no matter what order the statements are in.
    if (Reset) begin
      state         <= IDLE;
      Read_data_MEM <= 32'h0;
    end else begin
      state <= next_state;
      if (rd_en) begin
        Read_data_MEM <= ram[ram_addr];
      end
    end
  end

  // RAM write port. The write enable is already suppressed while Reset is high.
  always_ff @(posedge Clk) begin
    // NOTE: the RAM array is deliberately not reset. Its contents survive
    // Reset, and leaving it unreset lets it map onto a plain block RAM.
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit.
// A reference memory model predicts load data. Expected load results are
// queued when a load is issued and compared when the unit reports completion.
module tb_mem_access_unit;

  localparam int AW = 8;

  logic        Clk;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic        MemWrite64;
  logic [31:0] Adrs_MEM;
  logic [31:0] Rt_data_MEM;
  logic [63:0] Rt_data64_MEM;
  logic [31:0] Read_data_MEM;
  logic        Mem_stall;
  logic        Mem_done;

  mem_access_unit #(.AW(AW)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemWrite64    (MemWrite64),
    .Adrs_MEM      (Adrs_MEM),
    .Rt_data_MEM   (Rt_data_MEM),
    .Rt_data64_MEM (Rt_data64_MEM),
    .Read_data_MEM (Read_data_MEM),
    .Mem_stall     (Mem_stall),
    .Mem_done      (Mem_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef enum int {OP_RD, OP_WR, OP_WR64, OP_ALL} op_e;

  logic [31:0] model [0:(1<<AW)-1];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic clear_inputs();
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemWrite64    = 1'b0;
    Adrs_MEM      = 32'h0;
    Rt_data_MEM   = 32'h0;
    Rt_data64_MEM = 64'h0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one access and hold it until Mem_done is seen. Each call is
  // entered and left 1 ns after a rising edge, so calls can run back to back.
  task automatic access(input op_e op, input logic [31:0] addr,
                        input logic [31:0] d32, input logic [63:0] d64);
    logic [AW-1:0] i;
    int            stalls;
    int            exp_stalls;
    bit            done;
    logic [31:0]   exp;
    i             = addr[AW+1:2];
    MemRead       = (op == OP_RD)   || (op == OP_ALL);
    MemWrite      = (op == OP_WR)   || (op == OP_ALL);
    MemWrite64    = (op == OP_WR64) || (op == OP_ALL);
    Adrs_MEM      = addr;
    Rt_data_MEM   = d32;
    Rt_data64_MEM = d64;
    if (op == OP_RD) exp_q.push_back(model[i]);
    exp_stalls = (op == OP_WR) ? 0 : 1;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 6 && !done; c++) begin
      @(negedge Clk);
      check("stall_done_excl", {31'b0, Mem_stall & Mem_done}, 32'd0);
      if (Mem_done) done = 1'b1;
      else if (Mem_stall) stalls++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    if (op == OP_RD) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check("rd_data", Read_data_MEM, exp);
        last_rd = exp;
      end
    end else begin
      check("rd_hold", Read_data_MEM, last_rd);
    end
    case (op)
      OP_WR:  model[i] = d32;
      OP_WR64, OP_ALL: begin
        model[i]            = d64[31:0];
        model[i + AW'(1)]   = d64[63:32];
      end
      default: ;
    endcase
    step();
    clear_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_rd = 32'h0;
    clear_inputs();

    // A reset that arrives together with a request: outputs stay quiet and the load data is cleared.
    Reset   = 1'b1;
    MemRead = 1'b1;
    @(negedge Clk);
    check("rst_stall", {31'b0, Mem_stall}, 32'd0);
    check("rst_done", {31'b0, Mem_done}, 32'd0);
    step();
    Reset = 1'b0;
    clear_inputs();
    @(negedge Clk);
    check("rst_rd_data", Read_data_MEM, 32'h0);
    check("idle_stall", {31'b0, Mem_stall}, 32'd0);
    check("idle_done", {31'b0, Mem_done}, 32'd0);
    step();

    // 32-bit store followed by a load of the same word.
    access(OP_WR, 32'h10, 32'hDEADBEEF, 64'h0);
    access(OP_RD, 32'h10, 32'h0, 64'h0);

    // 64-bit store, then a load of each half.
    access(OP_WR64, 32'h20, 32'h0, 64'h11223344_55667788);
    access(OP_RD, 32'h20, 32'h0, 64'h0);
    access(OP_RD, 32'h24, 32'h0, 64'h0);

    // A 64-bit store at the last word wraps its high word to word 0.
    access(OP_WR64, 32'h3FC, 32'h0, 64'hCAFEF00D_0BADC0DE);
    access(OP_RD, 32'h3FC, 32'h0, 64'h0);
    access(OP_RD, 32'h0, 32'h0, 64'h0);

    // All three requests together: only the 64-bit store happens and the load data is held.
    access(OP_ALL, 32'h40, 32'hFFFF0000, 64'hA5A5A5A5_5A5A5A5A);
    access(OP_RD, 32'h40, 32'h0, 64'h0);
    access(OP_RD, 32'h44, 32'h0, 64'h0);

    // A store immediately followed by a load of the same word.
    access(OP_WR, 32'h0, 32'd5, 64'h0);
    access(OP_RD, 32'h0, 32'h0, 64'h0);

    // Reset during WR64_HI: the low word is kept and the high word is not written.
    access(OP_WR, 32'h84, 32'hAAAA5555, 64'h0);
    access(OP_RD, 32'h10, 32'h0, 64'h0);
    MemWrite64    = 1'b1;
    Adrs_MEM      = 32'h80;
    Rt_data64_MEM = 64'h12345678_9ABCDEF0;
    @(negedge Clk);
    check("wr64_rst_stall", {31'b0, Mem_stall}, 32'd1);
    step();
    Reset = 1'b1;
    @(negedge Clk);
    check("wr64_rst_stall_hi", {31'b0, Mem_stall}, 32'd0);
    check("wr64_rst_done_hi", {31'b0, Mem_done}, 32'd0);
    step();
    Reset = 1'b0;
    clear_inputs();
    model[8'h20] = 32'h9ABCDEF0;
    last_rd      = 32'h0;
    @(negedge Clk);
    check("wr64_rst_rd_data", Read_data_MEM, 32'h0);
    check("wr64_rst_idle", {30'b0, Mem_stall, Mem_done}, 32'd0);
    step();
    access(OP_RD, 32'h80, 32'h0, 64'h0);
    access(OP_RD, 32'h84, 32'h0, 64'h0);

    // Reset during RD_WAIT: the unit returns to IDLE with the load data cleared.
    MemRead  = 1'b1;
    Adrs_MEM = 32'h84;
    @(negedge Clk);
    check("rd_rst_stall", {31'b0, Mem_stall}, 32'd1);
    step();
    Reset = 1'b1;
    @(negedge Clk);
    check("rd_rst_done", {31'b0, Mem_done}, 32'd0);
    step();
    Reset = 1'b0;
    clear_inputs();
    last_rd = 32'h0;
    @(negedge Clk);
    check("rd_rst_rd_data", Read_data_MEM, 32'h0);
    step();

    // A store issued during a reset cycle must not reach the RAM.
    Reset       = 1'b1;
    MemWrite    = 1'b1;
    Adrs_MEM    = 32'h10;
    Rt_data_MEM = 32'h0BAD0BAD;
    step();
    Reset = 1'b0;
    clear_inputs();
    access(OP_RD, 32'h10, 32'h0, 64'h0);

    // Random traffic over words 0..15 with junk in the byte-offset bits.
    for (int w = 0; w < 16; w++) begin
      access(OP_WR, 32'(w << 2), $urandom, 64'h0);
    end
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          sel;
      a   = 32'(($urandom_range(0, 15) << 2) | ($urandom & 3));
      sel = $urandom_range(0, 2);
      if (sel == 0)      access(OP_RD, a, 32'h0, 64'h0);
      else if (sel == 1) access(OP_WR, a, $urandom, 64'h0);
      else               access(OP_WR64, a, 32'h0, {$urandom, $urandom});
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends even if the bench stalls somewhere.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter AW, default 8, SHALL set data RAM depth to 2^AW 32-bit words.
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 MemRead  input  1  SHALL request a 32-bit load.
REQ-005 MemWrite  input  1  SHALL request a 32-bit store.
REQ-006 MemWrite64  input  1  SHALL request a 64-bit store.
REQ-007 Adrs_MEM  input  32  SHALL carry the byte address; word index = Adrs_MEM[AW+1:2], bits [1:0] ignored.
REQ-008 Rt_data_MEM  input  32  SHALL carry 32-bit store data.
REQ-009 Rt_data64_MEM  input  64  SHALL carry 64-bit store data.
REQ-010 Read_data_MEM  output  32  SHALL carry registered load data.
REQ-011 Mem_stall  output  1  SHALL, when high, require the upstream pipeline to hold all inputs stable.
REQ-012 Mem_done  output  1  SHALL pulse high in the final cycle of every access.

Function
REQ-013 Storage SHALL be one single-port 2^AW x 32 RAM, at most one word access per cycle.
REQ-014 FSM states SHALL be IDLE, RD_WAIT, WR64_HI.
REQ-015 Request priority in IDLE SHALL be MemWrite64 > MemWrite > MemRead; lower-priority requests in the same cycle are ignored.
REQ-016 IDLE, MemWrite only: RAM[idx] <= Rt_data_MEM at the edge, Mem_stall=0, Mem_done=1, stay IDLE (1-cycle store).
REQ-017 IDLE, MemRead only: RAM[idx] read into Read_data_MEM at the edge, Mem_stall=1, Mem_done=0, go RD_WAIT.
REQ-018 RD_WAIT: Read_data_MEM valid, Mem_stall=0, Mem_done=1, go IDLE (2-cycle load).
REQ-019 IDLE, MemWrite64: RAM[idx] <= Rt_data64_MEM[31:0], Mem_stall=1, Mem_done=0, go WR64_HI.
REQ-020 WR64_HI: RAM[(idx+1) mod 2^AW] <= Rt_data64_MEM[63:32], Mem_stall=0, Mem_done=1, go IDLE.
REQ-021 High-word index SHALL wrap: idx=2^AW-1 writes high word to index 0.
REQ-022 Inputs sampled in RD_WAIT and WR64_HI SHALL be those held from the issuing cycle; new requests SHALL NOT be accepted outside IDLE.
REQ-023 IDLE with no request: Mem_stall=0, Mem_done=0, RAM unchanged.
REQ-024 Read_data_MEM SHALL hold its last loaded value until the next load updates it.
REQ-025 A load immediately following a store to the same word SHALL return the new data.
REQ-026 Mem_stall and Mem_done SHALL be combinational from state and request inputs; never both high.

Reset
REQ-027 Reset high at an edge SHALL force state IDLE and Read_data_MEM=32'h0, overriding any request that cycle.
REQ-028 While Reset is high, Mem_stall=0 and Mem_done=0.
REQ-029 RAM contents SHALL NOT be altered by reset and no RAM write SHALL occur in a reset cycle.
REQ-030 Reset in WR64_HI SHALL abort the high-word write; the low word already written remains.
REQ-031 Reset in RD_WAIT SHALL return to IDLE with Read_data_MEM=0.

Verification
REQ-032 MemWrite, Adrs=0x10, data 0xDEADBEEF; then MemRead Adrs=0x10 -> stall 1 cycle, Read_data_MEM=0xDEADBEEF in RD_WAIT, Mem_done=1 there.
REQ-033 MemWrite64, Adrs=0x20, data 0x11223344_55667788 -> Mem_stall=1 then 0; loads of 0x20/0x24 return 0x55667788/0x11223344.
REQ-034 MemWrite64 at Adrs=0x3FC (AW=8) -> word 255=low half, word 0=high half.
REQ-035 MemRead+MemWrite+MemWrite64 together, Adrs=0x40 -> only 64-bit store performed, Read_data_MEM unchanged.
REQ-036 Reset asserted during WR64_HI of store to 0x80 -> word 0x80 written, word 0x84 unchanged, state IDLE, Read_data_MEM=0.
REQ-037 Back-to-back: MemWrite 0x0=5, MemRead 0x0 next cycle -> Read_data_MEM=5 after one stall cycle.
